// File: rtl/freq_meter_core.sv
// ADC stream -> hysteresis edge detector -> gated BCD pulse counter -> latched reading.
// Latency: o_Pulse 1 cycle after the qualifying tick, result 1 cycle after end-of-gate; no backpressure.
module freq_meter_core #(
  parameter int ADC_W       = 12,
  parameter int DIGITS      = 4,
  parameter int SAMPLE_DIV  = 100,
  parameter int GATE_CYCLES = 10000000
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_En,
  input  logic [ADC_W-1:0]      i_Lv,
  input  logic [ADC_W-1:0]      i_ThHi,
  input  logic [ADC_W-1:0]      i_ThLo,
  input  logic                  i_Range,
  output logic                  o_Pulse,
  output logic [4*DIGITS-1:0]   o_Digits,
  output logic                  o_Ovf,
  output logic                  o_DP,
  output logic                  o_Valid
);

  localparam int PW = $clog2(SAMPLE_DIV);
  localparam int GW = $clog2(GATE_CYCLES);
  localparam int BW = 4 * DIGITS;

  localparam logic [PW-1:0] PRESC_LAST  = PW'(SAMPLE_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE   = PW'(1);
  localparam logic [GW-1:0] GATE_LAST_0 = GW'(GATE_CYCLES - 1);
  localparam logic [GW-1:0] GATE_LAST_1 = GW'(GATE_CYCLES / 10 - 1);
  localparam logic [GW-1:0] GATE_ONE    = GW'(1);

  typedef enum logic {ST_LOW, ST_HIGH} det_state_t;

  det_state_t      state, state_nxt;
  logic            pulse_nxt;
  logic [PW-1:0]   presc_cnt;
  logic            tick;
  logic [GW-1:0]   gate_cnt;
  logic [GW-1:0]   gate_last;
  logic            range_q, range_d, range_chg;
  logic            eog;
  logic [BW-1:0]   bcd_cnt, bcd_inc, bcd_nxt;
  logic            ovf, ovf_nxt;
  logic            carry;
  logic            count_en;

  assign tick      = i_En & (presc_cnt == PRESC_LAST);
  assign range_chg = range_q ^ range_d;
  assign gate_last = range_q ? GATE_LAST_1 : GATE_LAST_0;
  // A range switch in the same cycle pre-empts end-of-gate: the window restarts instead.
  assign eog       = i_En & ~range_chg & (gate_cnt == gate_last);
  assign count_en  = o_Pulse & i_En;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state   <= ST_LOW;
      o_Pulse <= 1'b0;
    end else begin
      state   <= state_nxt;
      o_Pulse <= pulse_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pulse_nxt = 1'b0;
    if (tick) begin
      case (state)
        ST_LOW: begin
          if (i_Lv >= i_ThHi) begin
            state_nxt = ST_HIGH;
            pulse_nxt = 1'b1;
          end
        end
        ST_HIGH: begin
          if (i_Lv <= i_ThLo) state_nxt = ST_LOW;
        end
      endcase
    end
  end

  // Decimal ripple increment; carry out of the top decade means all digits were 9.
  always_comb begin
    carry   = 1'b1;
    bcd_inc = bcd_cnt;
    for (int d = 0; d < DIGITS; d++) begin
      if (carry) begin
        if (bcd_cnt[4*d +: 4] == 4'd9) begin
          bcd_inc[4*d +: 4] = 4'd0;
        end else begin
          bcd_inc[4*d +: 4] = bcd_cnt[4*d +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  always_comb begin
    bcd_nxt = bcd_cnt;
    ovf_nxt = ovf;
    if (count_en) begin
      if (carry) ovf_nxt = 1'b1;
      else       bcd_nxt = bcd_inc;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      presc_cnt <= '0;
      gate_cnt  <= '0;
      bcd_cnt   <= '0;
      ovf       <= 1'b0;
      range_q   <= i_Range;
      range_d   <= i_Range;
      o_Digits  <= '0;
      o_Ovf     <= 1'b0;
      o_DP      <= 1'b0;
      o_Valid   <= 1'b0;
    end else begin
      range_q <= i_Range;
      range_d <= range_q;
      o_Valid <= eog;
      if (i_En) presc_cnt <= tick ? '0 : presc_cnt + PRESC_ONE;
      if (range_chg) begin
        gate_cnt <= '0;
        bcd_cnt  <= '0;
        ovf      <= 1'b0;
      end else if (eog) begin
        gate_cnt <= '0;
        bcd_cnt  <= '0;
        ovf      <= 1'b0;
        o_Digits <= bcd_nxt;
        o_Ovf    <= ovf_nxt;
        o_DP     <= range_q;
      end else begin
        if (i_En) gate_cnt <= gate_cnt + GATE_ONE;
        bcd_cnt <= bcd_nxt;
        ovf     <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter_core.sv
// Bench for freq_meter_core: vector table, corner sequences and random stimulus against an integer model.
module tb_freq_meter_core;

  localparam int DIV  = 4;
  localparam int GATE = 1000;

  logic        clk = 1'b0;
  logic        rst, en, rng;
  logic [11:0] lv = '0;
  logic [11:0] th_hi, th_lo;
  logic        pulse4, ovf4, dp4, valid4;
  logic [15:0] dig4;
  logic        pulse2, ovf2, dp2, valid2;
  logic [7:0]  dig2;

  always #5 clk = ~clk;

  freq_meter_core #(.ADC_W(12), .DIGITS(4), .SAMPLE_DIV(DIV), .GATE_CYCLES(GATE)) dut4 (
    .i_CLK(clk), .i_RST(rst), .i_En(en), .i_Lv(lv), .i_ThHi(th_hi), .i_ThLo(th_lo),
    .i_Range(rng), .o_Pulse(pulse4), .o_Digits(dig4), .o_Ovf(ovf4), .o_DP(dp4), .o_Valid(valid4));

  freq_meter_core #(.ADC_W(12), .DIGITS(2), .SAMPLE_DIV(DIV), .GATE_CYCLES(GATE)) dut2 (
    .i_CLK(clk), .i_RST(rst), .i_En(en), .i_Lv(lv), .i_ThHi(th_hi), .i_ThLo(th_lo),
    .i_Range(rng), .o_Pulse(pulse2), .o_Digits(dig2), .o_Ovf(ovf2), .o_DP(dp2), .o_Valid(valid2));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  // Stimulus waveform: 0 square, 1 in-band alternation, 2 manual level, 3 random.
  int          mode = 2;
  int          per = 40;
  int          wstart = 0;
  logic [11:0] man_lv = '0;
  int          cyc = 0;

  always @(posedge clk) begin
    #2;
    case (mode)
      0:       lv = (((cyc - wstart) % per) < per / 2) ? 12'd4000 : 12'd0;
      1:       lv = ((((cyc - wstart) / DIV) % 2) != 0) ? 12'd2200 : 12'd2000;
      2:       lv = man_lv;
      default: lv = 12'($urandom_range(0, 4095));
    endcase
  end

  // Reference model: an integer edge count per window, saturated only when compared.
  int m_presc, m_gate, m_cnt, lat_cnt;
  bit m_high, m_pulse, m_valid, lat_dp, m_rq, m_rd;
  bit chk_on = 0;

  always @(posedge clk) begin
    bit chg, tk, eg;
    int g, cnow;
    cyc++;
    if (rst) begin
      m_presc = 0; m_gate = 0; m_cnt = 0; lat_cnt = 0; lat_dp = 0;
      m_high = 0; m_pulse = 0; m_valid = 0; m_rq = rng; m_rd = rng;
    end else begin
      chg  = (m_rq != m_rd);
      g    = m_rq ? GATE / 10 : GATE;
      tk   = en && (m_presc == DIV - 1);
      cnow = m_cnt + ((m_pulse && en) ? 1 : 0);
      eg   = en && !chg && (m_gate == g - 1);
      m_valid = eg;
      if (chg) begin
        m_cnt = 0; m_gate = 0;
      end else if (eg) begin
        lat_cnt = cnow; lat_dp = m_rq; m_cnt = 0; m_gate = 0;
      end else begin
        m_cnt = cnow;
        if (en) m_gate++;
      end
      if (en) m_presc = tk ? 0 : m_presc + 1;
      m_pulse = tk && !m_high && (lv >= th_hi);
      if (tk) begin
        if (!m_high && lv >= th_hi) m_high = 1;
        else if (m_high && lv <= th_lo) m_high = 0;
      end
      m_rd = m_rq;
      m_rq = rng;
    end
  end

  always @(negedge clk) begin
    logic [15:0] e4, e2;
    if (chk_on && (m_pulse || m_valid || pulse4 || valid4 || pulse2 || valid2)) begin
      check("mdl_pulse4", 32'(pulse4), 32'(m_pulse));
      check("mdl_valid4", 32'(valid4), 32'(m_valid));
      check("mdl_pulse2", 32'(pulse2), 32'(m_pulse));
      check("mdl_valid2", 32'(valid2), 32'(m_valid));
      if (m_valid || valid4) begin
        e4 = to_bcd(sat(lat_cnt, 9999));
        e2 = to_bcd(sat(lat_cnt, 99));
        check("mdl_dig4", 32'(dig4), 32'(e4));
        check("mdl_ovf4", 32'(ovf4), 32'(lat_cnt > 9999));
        check("mdl_dp4", 32'(dp4), 32'(lat_dp));
        check("mdl_dig2", 32'(dig2), 32'(e2[7:0]));
        check("mdl_ovf2", 32'(ovf2), 32'(lat_cnt > 99));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wstart = cyc;
  endtask

  task automatic wait_valid(input string name, input int bound, output int n);
    n = 0;
    while (n < bound) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (valid4) break;
    end
    if (!valid4) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  typedef struct {
    bit          do_rst;
    bit          rng;
    int          mode;
    int          per;
    logic [15:0] e4;
    bit          eo4;
    logic [7:0]  e2;
    bit          eo2;
    bit          edp;
  } vec_t;

  vec_t tbl[5];
  int   pers[6] = '{6, 8, 12, 20, 40, 56};

  initial begin
    int n, len, en_mode;
    rst = 1'b1; en = 1'b1; rng = 1'b0; th_hi = 12'd2500; th_lo = 12'd1500;

    tbl[0] = '{1'b1, 1'b0, 0, 40, 16'h0025, 1'b0, 8'h25, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1, 40, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 0, 8,  16'h0125, 1'b0, 8'h99, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 0, 40, 16'h0025, 1'b0, 8'h25, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 0, 20, 16'h0005, 1'b0, 8'h05, 1'b0, 1'b1};

    do_reset();
    chk_on = 1;
    @(negedge clk);
    check("reset_outs", {27'd0, pulse4, valid4, ovf4, dp4, |dig4}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      rng = tbl[i].rng; mode = tbl[i].mode; per = tbl[i].per; wstart = cyc;
      if (tbl[i].do_rst) begin
        do_reset();
        wait_valid("tbl_first", 1100, n);
        check("tbl_latency", 32'(n), tbl[i].rng ? 32'd100 : 32'd1000);
      end else begin
        wait_valid("tbl_skip", 1100, n);
        wait_valid("tbl_next", 1100, n);
      end
      check("tbl_dig4", 32'(dig4), 32'(tbl[i].e4));
      check("tbl_ovf4", 32'(ovf4), 32'(tbl[i].eo4));
      check("tbl_dp4",  32'(dp4),  32'(tbl[i].edp));
      check("tbl_dig2", 32'(dig2), 32'(tbl[i].e2));
      check("tbl_ovf2", 32'(ovf2), 32'(tbl[i].eo2));
    end

    // Range toggled 50 cycles into a short gate: two restart cycles, then a full 100-cycle window.
    rng = 1'b1; mode = 0; per = 20;
    do_reset();
    wait_valid("tog_first", 150, n);
    step(49);
    rng = 1'b0;
    step(1);
    rng = 1'b1;
    @(negedge clk);
    check("tog_hold_dig", 32'(dig4), 32'h0005);
    wait_valid("tog_restart", 200, n);
    check("tog_latency", 32'(n), 32'd102);
    check("tog_dig", 32'(dig4), 32'h0005);
    check("tog_dp", 32'(dp4), 32'd1);

    // Reset half way through a gate.
    rng = 1'b0; mode = 0; per = 40;
    do_reset();
    wait_valid("mid_first", 1100, n);
    step(499);
    do_reset();
    @(negedge clk);
    check("mid_reset_outs", {27'd0, pulse4, valid4, ovf4, dp4, |dig4}, 32'd0);
    wait_valid("mid_after", 1100, n);
    check("mid_latency", 32'(n), 32'd1000);
    check("mid_dig", 32'(dig4), 32'h0025);

    // Shift the gate against the sample ticks so a pulse lands on end-of-gate.
    rng = 1'b0; mode = 2; man_lv = 12'd0;
    do_reset();
    step(3);
    rng = 1'b1;
    step(97);
    man_lv = 12'd4000;
    step(4);
    @(negedge clk);
    check("coin_pulse", 32'(pulse4), 32'd1);
    check("coin_novalid", 32'(valid4), 32'd0);
    step(1);
    @(negedge clk);
    check("coin_valid", 32'(valid4), 32'd1);
    check("coin_dig", 32'(dig4), 32'h0001);
    check("coin_dp", 32'(dp4), 32'd1);
    wait_valid("coin_next", 150, n);
    check("coin_next_lat", 32'(n), 32'd100);
    check("coin_next_dig", 32'(dig4), 32'h0000);

    // Random segments: waveforms, ranges, thresholds, enable gaps and occasional resets.
    for (int s = 0; s < 16; s++) begin
      mode    = $urandom_range(0, 3);
      per     = pers[$urandom_range(0, 5)];
      rng     = 1'($urandom_range(0, 1));
      th_hi   = 12'($urandom_range(2000, 3500));
      th_lo   = th_hi - 12'($urandom_range(1, 1000));
      wstart  = cyc;
      if ($urandom_range(0, 5) == 0) do_reset();
      len     = $urandom_range(200, 1500);
      en_mode = $urandom_range(0, 2);
      for (int c = 0; c < len; c++) begin
        en = (en_mode == 0) ? 1'b1 : ($urandom_range(0, 7) != 0);
        step(1);
      end
    end
    en = 1'b1;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
